intra4x4_mode_sched: RTL and testbench

Mode-decision sequencer for 4x4 luma intra prediction. It steps a shared, registered 9-mode predictor array through the H.264 Intra4x4 modes, skipping modes whose neighbours are unavailable. For each issued mode it computes the SAD of the returned prediction against the original block and reports the lowest-cost mode and its SAD. It sits between the macroblock controller (start/done) and the predictor mux (mode_sel/pred_in).

---
 rtl/intra4x4_pkg.sv | 40 ++++
 rtl/intra4x4_mode_sched_if.sv | 30 +++
 rtl/intra4x4_mode_sched_sad4x4.sv | 32 +++
 rtl/intra4x4_mode_sched.sv | 150 +++++++++++++++
 tb/tb_intra4x4_mode_sched.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/intra4x4_pkg.sv
// Shared constants, state encoding and the neighbour-availability rule
// for the Intra4x4 mode-decision sequencer.
package intra4x4_pkg;

  localparam logic [3:0] MODE_V   = 4'd0;
  localparam logic [3:0] MODE_H   = 4'd1;
  localparam logic [3:0] MODE_DC  = 4'd2;
  localparam logic [3:0] MODE_DDL = 4'd3;
  localparam logic [3:0] MODE_DDR = 4'd4;
  localparam logic [3:0] MODE_VR  = 4'd5;
  localparam logic [3:0] MODE_HD  = 4'd6;
  localparam logic [3:0] MODE_VL  = 4'd7;
  localparam logic [3:0] MODE_HU  = 4'd8;

  localparam int NUM_MODES = 9;
  localparam int SAD_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A mode can be evaluated only when every neighbour it reads is valid.
  // DC falls back to 128 when nothing is available, so it is always usable.
  function automatic logic mode_avail(input logic [3:0] mode,
                                      input logic       top,
                                      input logic       left);
    logic ok;
    case (mode)
      MODE_V, MODE_DDL, MODE_VL: ok = top;
      MODE_H, MODE_HU:           ok = left;
      MODE_DDR, MODE_VR, MODE_HD: ok = top & left;
      MODE_DC:                   ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/intra4x4_mode_sched_if.sv
// Bus between the macroblock controller / predictor mux and the
// Intra4x4 mode-decision sequencer.
interface intra4x4_mode_sched_if;
  import intra4x4_pkg::*;

  logic             start;
  logic             avail_top;
  logic             avail_left;
  logic [127:0]     orig;
  logic [127:0]     pred_in;
  logic             busy;
  logic [3:0]       mode_sel;
  logic             mode_vld;
  logic             done;
  logic [3:0]       best_mode;
  logic [SAD_W-1:0] best_sad;

  // Controller/predictor side
  modport master (
    output start, avail_top, avail_left, orig, pred_in,
    input  busy, mode_sel, mode_vld, done, best_mode, best_sad
  );

  // Sequencer side
  modport slave (
    input  start, avail_top, avail_left, orig, pred_in,
    output busy, mode_sel, mode_vld, done, best_mode, best_sad
  );

endinterface

// File: rtl/intra4x4_mode_sched_sad4x4.sv
// Combinational sum of absolute differences over one 4x4 block of
// 8-bit samples; the 12-bit result cannot overflow (16*255 = 4080).
module sad4x4
  import intra4x4_pkg::*;
(
  input  logic [127:0]     orig,
  input  logic [127:0]     pred,
  output logic [SAD_W-1:0] sad
);

  logic [7:0]       diff [16];
  logic [SAD_W-1:0] sum;

  // Per-sample absolute difference, subtracting the smaller from the larger
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      if (orig[8*k +: 8] >= pred[8*k +: 8]) diff[k] = orig[8*k +: 8] - pred[8*k +: 8];
      else                                  diff[k] = pred[8*k +: 8] - orig[8*k +: 8];
    end
  end

  // Accumulate the sixteen differences
  always_comb begin
    sum = '0;
    for (int k = 0; k < 16; k++) begin
      sum = sum + {4'b0000, diff[k]};
    end
  end

  assign sad = sum;

endmodule

// File: rtl/intra4x4_mode_sched.sv
// Intra4x4 mode-decision sequencer: issues modes 0..8 one per cycle to the
// shared predictor, computes the SAD of each returned prediction one cycle
// later and keeps the cheapest available mode (lowest index wins ties).
module intra4x4_mode_sched
  import intra4x4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  intra4x4_mode_sched_if.slave bus
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       mode_sel_q, mode_sel_d;
  logic             mode_vld_q, mode_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             top_q, top_d;
  logic             left_q, left_d;
  logic             load_best;

  logic             tag_vld_q, tag_vld_d;
  logic [3:0]       tag_mode_q, tag_mode_d;
  logic             sad_vld_q, sad_vld_d;
  logic [3:0]       sad_mode_q, sad_mode_d;
  logic [SAD_W-1:0] sad_q, sad_d;
  logic [SAD_W-1:0] sad_now;
  logic [3:0]       best_mode_q, best_mode_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;

  sad4x4 u_sad (
    .orig (bus.orig),
    .pred (bus.pred_in),
    .sad  (sad_now)
  );

  // Sequencer: accept start, walk the nine modes, then wait out the pipeline
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_sel_d = mode_sel_q;
    mode_vld_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    top_d      = top_q;
    left_d     = left_q;
    load_best  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ISSUE;
          cnt_d      = 4'd0;
          mode_sel_d = MODE_V;
          mode_vld_d = mode_avail(MODE_V, bus.avail_top, bus.avail_left);
          top_d      = bus.avail_top;
          left_d     = bus.avail_left;
          busy_d     = 1'b1;
          load_best  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == MODE_HU) begin
          state_d = ST_DRAIN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d      = cnt_q + 4'd1;
          mode_sel_d = cnt_q + 4'd1;
          mode_vld_d = mode_avail(cnt_q + 4'd1, top_q, left_q);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Two-stage SAD/compare pipeline; the tag stage aligns the issued mode
  // with the prediction that comes back one cycle later
  always_comb begin
    tag_vld_d   = mode_vld_q;
    tag_mode_d  = mode_sel_q;
    sad_vld_d   = tag_vld_q;
    sad_mode_d  = tag_mode_q;
    sad_d       = sad_now;
    best_mode_d = best_mode_q;
    best_sad_d  = best_sad_q;
    if (load_best) begin
      best_mode_d = MODE_V;
      best_sad_d  = '1;
    end else if (sad_vld_q && (sad_q < best_sad_q)) begin
      best_mode_d = sad_mode_q;
      best_sad_d  = sad_q;
    end
  end

  // State and pipeline registers; reset abandons any run in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mode_sel_q  <= 4'd0;
      mode_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      top_q       <= 1'b0;
      left_q      <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_mode_q  <= 4'd0;
      sad_vld_q   <= 1'b0;
      sad_mode_q  <= 4'd0;
      sad_q       <= '0;
      best_mode_q <= 4'd0;
      best_sad_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_sel_q  <= mode_sel_d;
      mode_vld_q  <= mode_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      top_q       <= top_d;
      left_q      <= left_d;
      tag_vld_q   <= tag_vld_d;
      tag_mode_q  <= tag_mode_d;
      sad_vld_q   <= sad_vld_d;
      sad_mode_q  <= sad_mode_d;
      sad_q       <= sad_d;
      best_mode_q <= best_mode_d;
      best_sad_q  <= best_sad_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mode_sel  = mode_sel_q;
  assign bus.mode_vld  = mode_vld_q;
  assign bus.done      = done_q;
  assign bus.best_mode = best_mode_q;
  assign bus.best_sad  = best_sad_q;

endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// Directed bench for the Intra4x4 mode-decision sequencer: drives complete
// decisions with hand-built prediction tables and checks every cycle.
module tb_intra4x4_mode_sched;

  logic clk;
  logic reset;

  intra4x4_mode_sched_if bus();

  intra4x4_mode_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           checks   = 0;
  int           failures = 0;
  logic [127:0] pred_tab [9];
  time          t_done1, t_done2, t_last_done;

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] with_sample(input logic [127:0] base, input int k,
                                               input logic [7:0] v);
    logic [127:0] r;
    r = base;
    r[8*k +: 8] = v;
    return r;
  endfunction

  // One full decision: start in the current cycle (cycle 0), feed pred_tab
  // in cycles 2..10, check issue, busy, done and the final result.
  task automatic run_decision(input string name, input logic top, input logic left,
                              input logic hold, input logic [8:0] exp_vld,
                              input logic [3:0] exp_mode, input logic [11:0] exp_sad);
    bus.start      = 1'b1;
    bus.avail_top  = top;
    bus.avail_left = left;
    tick();
    if (!hold) bus.start = 1'b0;
    bus.avail_top  = ~top;
    bus.avail_left = ~left;
    for (int c = 1; c <= 12; c++) begin
      if (c >= 2 && c <= 10) bus.pred_in = pred_tab[c-2];
      else                   bus.pred_in = ~bus.orig;
      if (c <= 9) begin
        check({name, " mode_sel"}, {28'd0, bus.mode_sel}, c - 1);
        check({name, " mode_vld"}, {31'd0, bus.mode_vld}, {31'd0, exp_vld[c-1]});
      end
      check({name, " busy"}, {31'd0, bus.busy}, {31'd0, (c <= 11)});
      check({name, " done"}, {31'd0, bus.done}, {31'd0, (c == 12)});
      if (c == 12) begin
        t_last_done = $time;
        check({name, " best_mode"}, {28'd0, bus.best_mode}, {28'd0, exp_mode});
        check({name, " best_sad"},  {20'd0, bus.best_sad},  {20'd0, exp_sad});
      end else begin
        tick();
      end
    end
  endtask

  // Directed sequence
  initial begin
    bus.start      = 1'b0;
    bus.avail_top  = 1'b0;
    bus.avail_left = 1'b0;
    bus.orig       = '0;
    bus.pred_in    = '0;
    reset          = 1'b1;
    tick();
    check("reset busy",      {31'd0, bus.busy},      32'd0);
    check("reset done",      {31'd0, bus.done},      32'd0);
    check("reset mode_vld",  {31'd0, bus.mode_vld},  32'd0);
    check("reset mode_sel",  {28'd0, bus.mode_sel},  32'd0);
    check("reset best_mode", {28'd0, bus.best_mode}, 32'd0);
    check("reset best_sad",  {20'd0, bus.best_sad},  32'd0);
    reset = 1'b0;
    tick();

    // Both available: only mode 5 matches orig exactly
    $display("[TB] run 1: all available, exact match on mode 5");
    bus.orig = fill(8'h00);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'hFF);
    pred_tab[5] = fill(8'h00);
    run_decision("t1", 1'b1, 1'b1, 1'b0, 9'h1FF, 4'd5, 12'd0);

    // Modes 3 and 6 tie at 40, everything else 256: lower index wins
    $display("[TB] run 2: tie between modes 3 and 6");
    bus.orig = fill(8'h10);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'h20);
    pred_tab[3] = with_sample(with_sample(fill(8'h10), 0, 8'h24), 1, 8'h24);
    pred_tab[6] = with_sample(with_sample(fill(8'h10), 14, 8'h24), 15, 8'h24);
    run_decision("t2", 1'b1, 1'b1, 1'b0, 9'h1FF, 4'd3, 12'd40);

    // Left only: perfect predictions on unavailable modes must be ignored
    $display("[TB] run 3: left neighbours only");
    bus.orig = fill(8'h40);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'h40);
    pred_tab[1] = fill(8'h43);
    pred_tab[2] = fill(8'h42);
    pred_tab[8] = fill(8'h3F);
    run_decision("t3", 1'b0, 1'b1, 1'b0, 9'h106, 4'd8, 12'd16);

    // No neighbours: DC is the only candidate
    $display("[TB] run 4: no neighbours");
    bus.orig = fill(8'h80);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'h80);
    pred_tab[2] = fill(8'h7F);
    run_decision("t4", 1'b0, 1'b0, 1'b0, 9'h004, 4'd2, 12'd16);

    // Reset in cycle 6 of a run
    $display("[TB] run 5: reset mid-run");
    bus.orig = fill(8'h00);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'h00);
    bus.start      = 1'b1;
    bus.avail_top  = 1'b1;
    bus.avail_left = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      bus.pred_in = fill(8'h00);
      tick();
    end
    check("pre-reset busy",     {31'd0, bus.busy},     32'd1);
    check("pre-reset mode_sel", {28'd0, bus.mode_sel}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("async busy",      {31'd0, bus.busy},      32'd0);
    check("async mode_vld",  {31'd0, bus.mode_vld},  32'd0);
    check("async mode_sel",  {28'd0, bus.mode_sel},  32'd0);
    check("async best_mode", {28'd0, bus.best_mode}, 32'd0);
    check("async best_sad",  {20'd0, bus.best_sad},  32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("post-reset done", {31'd0, bus.done}, 32'd0);
      check("post-reset busy", {31'd0, bus.busy}, 32'd0);
      tick();
    end
    bus.orig = fill(8'h00);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'hFF);
    pred_tab[5] = fill(8'h00);
    run_decision("t5", 1'b1, 1'b1, 1'b0, 9'h1FF, 4'd5, 12'd0);

    // start held through a run, then accepted again in the done cycle
    $display("[TB] run 6: held start and back-to-back");
    bus.orig = fill(8'h10);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'h20);
    pred_tab[3] = with_sample(with_sample(fill(8'h10), 0, 8'h24), 1, 8'h24);
    pred_tab[6] = with_sample(with_sample(fill(8'h10), 14, 8'h24), 15, 8'h24);
    run_decision("t6a", 1'b1, 1'b1, 1'b1, 9'h1FF, 4'd3, 12'd40);
    t_done1 = t_last_done;
    bus.orig = fill(8'h80);
    for (int m = 0; m < 9; m++) pred_tab[m] = fill(8'h80);
    pred_tab[2] = fill(8'h7F);
    run_decision("t6b", 1'b0, 1'b0, 1'b0, 9'h004, 4'd2, 12'd16);
    t_done2 = t_last_done;
    check("b2b spacing", 32'(t_done2 - t_done1), 32'd120);

    // Result must be held after done while idle
    tick();
    tick();
    check("hold best_mode", {28'd0, bus.best_mode}, 32'd2);
    check("hold best_sad",  {20'd0, bus.best_sad},  32'd16);
    check("hold done",      {31'd0, bus.done},      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
